bnn_seq_ctrl: RTL and testbench

BNN_SEQ_CTRL -- requirements
Module: bnn_seq_ctrl

---
 rtl/bnn_pkg.sv | 21 ++
 rtl/bnn_seq_ctrl_if.sv | 31 +++
 rtl/bnn_seq_ctrl.sv | 147 ++++++++++++++
 tb/tb_bnn_seq_ctrl.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/bnn_pkg.sv
// Shared definitions for the BNN frame sequencer: FSM state type,
// parameter defaults and the datapath result codes.
package bnn_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_RUN   = 3'd2,
        ST_CMP   = 3'd3,
        ST_CAPT  = 3'd4,
        ST_OUT   = 3'd5
    } state_t;

    localparam int N_COLS_DEF = 36;
    localparam int IDX_W_DEF  = 6;
    localparam int TO_CYC_DEF = 1024;

    localparam logic [1:0] RES_SPEECH    = 2'b10;
    localparam logic [1:0] RES_NONSPEECH = 2'b01;

endpackage : bnn_pkg

// File: rtl/bnn_seq_ctrl_if.sv
// Column stream, datapath strobes and result handshake of the BNN
// sequencer. master = controller side, slave = column source, datapath
// and result sink.
interface bnn_seq_ctrl_if
    import bnn_pkg::*;
#(
    parameter int IDX_W = IDX_W_DEF
) ();
    logic             col_valid;
    logic             col_ready;
    logic             dp_acc_clr;
    logic             dp_col_en;
    logic [IDX_W-1:0] dp_col_idx;
    logic             dp_cmp_en;
    logic [1:0]       dp_result;
    logic             res_valid;
    logic [1:0]       res_data;
    logic             res_ready;

    modport master (
        input  col_valid, dp_result, res_ready,
        output col_ready, dp_acc_clr, dp_col_en, dp_col_idx, dp_cmp_en,
               res_valid, res_data
    );

    modport slave (
        output col_valid, dp_result, res_ready,
        input  col_ready, dp_acc_clr, dp_col_en, dp_col_idx, dp_cmp_en,
               res_valid, res_data
    );
endinterface : bnn_seq_ctrl_if

// File: rtl/bnn_seq_ctrl.sv
// BNN frame sequencer: clears the accumulators, streams N_COLS column
// beats into the datapath, triggers the compare, captures the class
// result and holds it until the consumer takes it.
// Optional feature macro: BNN_SEQ_TIMEOUT_EN adds a RUN stall watchdog
// with a sticky timeout_err output.
module bnn_seq_ctrl
    import bnn_pkg::*;
#(
    parameter int N_COLS = N_COLS_DEF,
    parameter int IDX_W  = IDX_W_DEF,
    parameter int TO_CYC = TO_CYC_DEF
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic           abort,
    bnn_seq_ctrl_if.master bus,
    output logic           busy,
`ifdef BNN_SEQ_TIMEOUT_EN
    output logic           timeout_err,
`endif
    output logic [15:0]    frame_cnt
);

    // Elaboration-time sanity: the index must reach N_COLS-1, timeout >= 1.
    if ((N_COLS < 1) || (((N_COLS - 1) >> IDX_W) != 0)) begin : g_bad_idx
        $error("bnn_seq_ctrl: IDX_W too narrow for N_COLS");
    end
    if (TO_CYC < 1) begin : g_bad_to
        $error("bnn_seq_ctrl: TO_CYC must be at least 1");
    end

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_COLS - 1);

    state_t           state_reg;
    logic [IDX_W-1:0] idx_reg;
    logic [1:0]       res_data_reg;
    logic             res_valid_reg;
    logic [15:0]      frame_cnt_reg;

    logic beat;
    logic abort_hit;
    logic kill;

    // Strobes are decodes of the state register, so they are mutually
    // exclusive by construction and all low while reset holds IDLE.
    assign bus.col_ready  = (state_reg == ST_RUN);
    assign bus.dp_acc_clr = (state_reg == ST_CLEAR);
    assign bus.dp_cmp_en  = (state_reg == ST_CMP);
    assign beat           = bus.col_valid && bus.col_ready;
    assign bus.dp_col_en  = beat;
    assign bus.dp_col_idx = idx_reg;
    assign bus.res_valid  = res_valid_reg;
    assign bus.res_data   = res_data_reg;
    assign busy           = (state_reg != ST_IDLE);
    assign frame_cnt      = frame_cnt_reg;

    assign abort_hit = abort && (state_reg != ST_IDLE);

`ifdef BNN_SEQ_TIMEOUT_EN
    localparam int SW = $clog2(TO_CYC + 1);

    logic [SW-1:0] stall_cnt_reg;
    logic          timeout_err_reg;
    logic          to_hit;

    // The TO_CYC-th consecutive beatless RUN cycle trips the watchdog.
    assign to_hit      = (state_reg == ST_RUN) && !beat &&
                         (stall_cnt_reg == SW'(TO_CYC - 1));
    assign kill        = abort_hit || to_hit;
    assign timeout_err = timeout_err_reg;

    // Stall counter runs only across consecutive beatless RUN cycles; error is sticky.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_reg   <= '0;
            timeout_err_reg <= 1'b0;
        end else begin
            if (to_hit) begin
                timeout_err_reg <= 1'b1;
            end
            if ((state_reg == ST_RUN) && !beat && !kill) begin
                stall_cnt_reg <= stall_cnt_reg + SW'(1);
            end else begin
                stall_cnt_reg <= '0;
            end
        end
    end
`else
    assign kill = abort_hit;
`endif

    // Frame sequencer: abort/timeout outranks every other transition.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= ST_IDLE;
            idx_reg       <= '0;
            res_data_reg  <= 2'b00;
            res_valid_reg <= 1'b0;
            frame_cnt_reg <= 16'd0;
        end else if (kill) begin
            state_reg     <= ST_IDLE;
            idx_reg       <= '0;
            res_valid_reg <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (start && !abort) begin
                        state_reg <= ST_CLEAR;
                    end
                end
                ST_CLEAR: begin
                    state_reg <= ST_RUN;
                end
                ST_RUN: begin
                    if (beat) begin
                        if (idx_reg == IDX_LAST) begin
                            idx_reg   <= '0;
                            state_reg <= ST_CMP;
                        end else begin
                            idx_reg <= idx_reg + IDX_W'(1);
                        end
                    end
                end
                ST_CMP: begin
                    state_reg <= ST_CAPT;
                end
                ST_CAPT: begin
                    res_data_reg  <= bus.dp_result;
                    res_valid_reg <= 1'b1;
                    state_reg     <= ST_OUT;
                end
                ST_OUT: begin
                    if (bus.res_ready) begin
                        frame_cnt_reg <= frame_cnt_reg + 16'd1;
                        res_valid_reg <= 1'b0;
                        state_reg     <= start ? ST_CLEAR : ST_IDLE;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

endmodule : bnn_seq_ctrl

// File: tb/tb_bnn_seq_ctrl.sv
// Self-checking bench for bnn_seq_ctrl: table of frame vectors plus
// hand-written abort, back-to-back, reset-in-CMP and (with
// BNN_SEQ_TIMEOUT_EN) stall-timeout sequences. Results go through a
// scoreboard queue filled when each frame is started.
module tb_bnn_seq_ctrl;
    import bnn_pkg::*;

    localparam int NC = 36;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        abort;
    logic        busy;
    logic [15:0] frame_cnt;
`ifdef BNN_SEQ_TIMEOUT_EN
    logic        timeout_err;
`endif

    bnn_seq_ctrl_if #(.IDX_W(6)) bus ();

    bnn_seq_ctrl #(
        .N_COLS (NC),
        .IDX_W  (6),
        .TO_CYC (16)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .abort       (abort),
        .bus         (bus.master),
        .busy        (busy),
`ifdef BNN_SEQ_TIMEOUT_EN
        .timeout_err (timeout_err),
`endif
        .frame_cnt   (frame_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] res;
        int         gap;
        int         rdy_wait;
        int         exp_len;
    } vec_t;

    vec_t       vecs[5];
    logic [1:0] exp_q[$];
    int         checks = 0;
    int         errors = 0;
    int         exp_fc = 0;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One frame: start at k=0, col_valid when k%(gap+1)==gap, res_ready
    // withheld for rdy_wait valid cycles. exp_len is the handshake cycle.
    task automatic run_frame(input vec_t v, input bit hold_start);
        int k = 0, beats = 0, seen = 0, clr_n = 0, cmp_n = 0, first_rdy = -1;
        bit excl_bad = 1'b0, done = 1'b0, next_rr, chg_res = 1'b0;
        logic [1:0] got;
        exp_q.push_back(v.res);
        bus.dp_result = v.res;
        bus.res_ready = (v.rdy_wait == 0);
        start = 1'b1;
        while (!done && k < 400) begin
            bus.col_valid = ((k % (v.gap + 1)) == v.gap);
            if (k > 0 && !hold_start) start = 1'b0;
            @(negedge clk);
            if (bus.col_ready && first_rdy < 0) first_rdy = k;
            if (bus.dp_acc_clr) clr_n++;
            if (bus.dp_cmp_en) cmp_n++;
            if ((int'(bus.dp_acc_clr) + int'(bus.dp_col_en) + int'(bus.dp_cmp_en)) > 1)
                excl_bad = 1'b1;
            if (bus.dp_col_en) begin
                chk("col_idx", int'(bus.dp_col_idx), beats);
                beats++;
            end
            if (bus.res_valid) begin
                seen++;
                chg_res = 1'b1;
                if (exp_q.size() == 0) begin
                    chk("unexpected_result", 1, 0);
                    done = 1'b1;
                end else begin
                    chk("res_stable", int'(bus.res_data), int'(exp_q[0]));
                    if (bus.res_ready) begin
                        got = exp_q.pop_front();
                        chk("res_data", int'(bus.res_data), int'(got));
                        chk("frame_len", k, v.exp_len);
                        exp_fc = (exp_fc + 1) % 65536;
                        done = 1'b1;
                    end
                end
            end
            next_rr = (seen >= v.rdy_wait);
            tick();
            k++;
            bus.res_ready = next_rr;
            if (chg_res) bus.dp_result = ~v.res;
        end
        if (!done) chk("frame_timeout", k, v.exp_len);
        bus.col_valid = 1'b0;
        chk("beats", beats, NC);
        chk("acc_clr_pulses", clr_n, 1);
        chk("cmp_en_pulses", cmp_n, 1);
        chk("strobe_excl", int'(excl_bad), 0);
        chk("start_to_ready", first_rdy, 2);
        @(negedge clk);
        chk("frame_cnt", int'(frame_cnt), exp_fc);
        chk("res_valid_clr", int'(bus.res_valid), 0);
        chk("next_clear", int'(bus.dp_acc_clr), int'(hold_start));
        $display("frame res=%b gap=%0d wait=%0d len=%0d beats=%0d frame_cnt=%0d",
                 v.res, v.gap, v.rdy_wait, k - 1, beats, frame_cnt);
        tick();
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int n, k;
        bit bad;
        vecs[0] = '{res: RES_SPEECH,    gap: 0, rdy_wait: 0,  exp_len: 40};
        vecs[1] = '{res: RES_NONSPEECH, gap: 1, rdy_wait: 0,  exp_len: 76};
        vecs[2] = '{res: RES_SPEECH,    gap: 2, rdy_wait: 3,  exp_len: 113};
        vecs[3] = '{res: RES_NONSPEECH, gap: 0, rdy_wait: 10, exp_len: 50};
        vecs[4] = '{res: RES_NONSPEECH, gap: 0, rdy_wait: 0,  exp_len: 40};

        rst_n = 1'b0; start = 1'b0; abort = 1'b0;
        bus.col_valid = 1'b1; bus.dp_result = 2'b11; bus.res_ready = 1'b1;
        tick(); tick();
        @(negedge clk);
        chk("rst_busy", int'(busy), 0);
        chk("rst_col_ready", int'(bus.col_ready), 0);
        chk("rst_col_en", int'(bus.dp_col_en), 0);
        chk("rst_acc_clr", int'(bus.dp_acc_clr), 0);
        chk("rst_cmp_en", int'(bus.dp_cmp_en), 0);
        chk("rst_res_valid", int'(bus.res_valid), 0);
        chk("rst_res_data", int'(bus.res_data), 0);
        chk("rst_frame_cnt", int'(frame_cnt), 0);
        chk("rst_col_idx", int'(bus.dp_col_idx), 0);
`ifdef BNN_SEQ_TIMEOUT_EN
        chk("rst_timeout_err", int'(timeout_err), 0);
`endif
        tick();
        bus.col_valid = 1'b0;
        rst_n = 1'b1;

        // Table-driven frames
        for (int i = 0; i < 5; i++) run_frame(vecs[i], 1'b0);

        // Back-to-back: start held through the handshake, then abort the new frame
        run_frame(vecs[3], 1'b1);
        start = 1'b0;
        abort = 1'b1;
        @(negedge clk);
        tick();
        abort = 1'b0;
        @(negedge clk);
        chk("b2b_abort_busy", int'(busy), 0);
        chk("b2b_abort_fc", int'(frame_cnt), exp_fc);
        tick();

        // Abort after beat 20, with beats still offered
        start = 1'b1; bus.col_valid = 1'b1; bus.dp_result = RES_NONSPEECH; bus.res_ready = 1'b1;
        n = 0; k = 0;
        while (n < 20 && k < 100) begin
            @(negedge clk);
            if (bus.dp_col_en) n++;
            tick();
            start = 1'b0;
            k++;
        end
        chk("abort_beats_before", n, 20);
        abort = 1'b1;
        @(negedge clk);
        tick();
        abort = 1'b0;
        @(negedge clk);
        chk("abort_busy", int'(busy), 0);
        chk("abort_col_ready", int'(bus.col_ready), 0);
        chk("abort_res_valid", int'(bus.res_valid), 0);
        chk("abort_frame_cnt", int'(frame_cnt), exp_fc);
        tick();
        bad = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (bus.dp_col_en || bus.res_valid || busy) bad = 1'b1;
            tick();
        end
        chk("abort_stays_idle", int'(bad), 0);
        bus.col_valid = 1'b0;
        run_frame(vecs[0], 1'b0);

        // Reset asserted during CMP
        start = 1'b1; bus.col_valid = 1'b1; bus.dp_result = RES_SPEECH;
        k = 0;
        bad = 1'b1;
        while (k < 100) begin
            @(negedge clk);
            if (bus.dp_cmp_en) begin
                bad = 1'b0;
                break;
            end
            tick();
            start = 1'b0;
            k++;
        end
        chk("reach_cmp", int'(bad), 0);
        start = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("arst_busy", int'(busy), 0);
        chk("arst_cmp_en", int'(bus.dp_cmp_en), 0);
        chk("arst_res_valid", int'(bus.res_valid), 0);
        chk("arst_frame_cnt", int'(frame_cnt), 0);
        exp_fc = 0;
        tick(); tick();
        rst_n = 1'b1;
        bus.col_valid = 1'b0;
        bad = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (bus.res_valid || busy) bad = 1'b1;
            tick();
        end
        chk("arst_no_result", int'(bad), 0);

`ifdef BNN_SEQ_TIMEOUT_EN
        // Stall timeout with TO_CYC=16
        start = 1'b1; bus.col_valid = 1'b0;
        for (int i = 0; i <= 18; i++) begin
            @(negedge clk);
            if (i == 17) begin
                chk("to_busy_before", int'(busy), 1);
                chk("to_err_before", int'(timeout_err), 0);
            end
            if (i == 18) begin
                chk("to_busy_after", int'(busy), 0);
                chk("to_err_after", int'(timeout_err), 1);
                chk("to_frame_cnt", int'(frame_cnt), exp_fc);
            end
            tick();
            start = 1'b0;
        end
        run_frame(vecs[0], 1'b0);
        chk("to_err_sticky", int'(timeout_err), 1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_bnn_seq_ctrl
